wb_ctrl: RTL

- Registered, parametrised writeback controller for the KGP RISC datapath.
- Sits between execute/memory and the register file.
- Decodes opcode/fcode to choose the destination register and data source (ALU result, return address, or load data).
- Holds load instructions until the memory response arrives, with a timeout, and issues exactly one register-file write per retired instruction.

---
 rtl/wb_ctrl_if.sv | 41 ++++
 rtl/wb_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/wb_ctrl_if.sv
// Writeback controller bus: execute/memory side handshake, register-file
// write port and forwarding (bypass) port, grouped for wb_ctrl.
interface wb_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [3:0]        fcode;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rt_a;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] ra;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              mem_err;
    logic              byp_valid;
    logic [REG_AW-1:0] byp_addr;
    logic [DATA_W-1:0] byp_data;

    // Upstream pipeline / environment side
    modport master (
        output in_valid, opcode, fcode, rs_a, rt_a, alu_out, ra,
               mem_valid, mem_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, mem_err,
               byp_valid, byp_addr, byp_data
    );

    // Writeback controller side
    modport slave (
        input  in_valid, opcode, fcode, rs_a, rt_a, alu_out, ra,
               mem_valid, mem_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, mem_err,
               byp_valid, byp_addr, byp_data
    );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller for the KGP RISC datapath.
// Decodes opcode/fcode into a single register-file write per retired
// instruction; loads wait in WAIT_MEM for memory data with a timeout.
// Optional forwarding port enabled by defining WB_BYPASS_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready to accept one instruction per cycle
//   WAIT_MEM | load accepted, waiting for mem_valid or timeout
module wb_ctrl #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_REG    = 31,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int ZERO_REG    = 1
) (
    input  logic     clk,
    input  logic     rst,
    wb_ctrl_if.slave bus
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t            state, state_n;
    logic [TO_W-1:0]   cnt, cnt_n;
    logic [REG_AW-1:0] ld_addr, ld_addr_n;
    logic              wr_en_q, wr_en_n;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_n;
    logic [DATA_W-1:0] wr_data_q, wr_data_n;
    logic              mem_err_q, mem_err_n;
    logic              wr_req;
    logic [REG_AW-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    // State, timeout counter, latched load address and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_addr   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ld_addr   <= ld_addr_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            mem_err_q <= mem_err_n;
        end
    end

    // Decode, next-state and next-output selection
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ld_addr_n = ld_addr;
        mem_err_n = 1'b0;
        wr_req    = 1'b0;
        req_addr  = '0;
        req_data  = '0;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.opcode)
                        3'd0, 3'd1: begin
                            wr_req   = 1'b1;
                            req_addr = bus.rs_a;
                            req_data = bus.alu_out;
                        end
                        3'd2: begin
                            if (bus.fcode == 4'd0) begin
                                state_n   = WAIT_MEM;
                                cnt_n     = '0;
                                ld_addr_n = bus.rt_a;
                            end
                        end
                        3'd3: begin
                            if (bus.fcode == 4'd9) begin
                                wr_req   = 1'b1;
                                req_addr = REG_AW'(LINK_REG);
                                req_data = bus.ra;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_MEM: begin
                // Data arriving on the terminal-count cycle still wins
                if (bus.mem_valid) begin
                    wr_req   = 1'b1;
                    req_addr = ld_addr;
                    req_data = bus.mem_data;
                    state_n  = IDLE;
                end else if (cnt == TO_LIMIT) begin
                    mem_err_n = 1'b1;
                    state_n   = IDLE;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Register 0 writes are dropped but the instruction still retires
        wr_en_n   = wr_req && !((ZERO_REG != 0) && (req_addr == '0));
        wr_addr_n = wr_req ? req_addr : wr_addr_q;
        wr_data_n = wr_req ? req_data : wr_data_q;
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state == WAIT_MEM);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.mem_err  = mem_err_q;

`ifdef WB_BYPASS_EN
    // Forward the write that lands on wr_* next cycle
    assign bus.byp_valid = wr_en_n;
    assign bus.byp_addr  = wr_addr_n;
    assign bus.byp_data  = wr_data_n;
`else
    assign bus.byp_valid = 1'b0;
    assign bus.byp_addr  = '0;
    assign bus.byp_data  = '0;
`endif

endmodule
